// File: rtl/store_commit_ctrl.sv
// Committed-store buffer: accepts stores at the commit point, drains them in order
// over the data-side SRAM-like bus, and answers load conflict probes.
module sb_entry_match #(
    parameter int WORD_W = 30
) (
    input  logic              vld,
    input  logic              has_bytes,
    input  logic [WORD_W-1:0] st_word,
    input  logic [WORD_W-1:0] ld_word,
    output logic              hit
);
    assign hit = vld && has_bytes && (st_word == ld_word);
endmodule

module store_commit_ctrl #(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         cs_store_valid,
    output logic                         cs_store_ready,
    input  logic [ADDR_W-1:0]            cs_store_addr,
    input  logic [DATA_W-1:0]            cs_store_wdata,
    input  logic [DATA_W/8-1:0]          cs_store_wstrb,
    input  logic [1:0]                   cs_store_size,
    output logic                         data_req,
    output logic                         data_wr,
    output logic [1:0]                   data_size,
    output logic [ADDR_W-1:0]            data_addr,
    output logic [DATA_W-1:0]            data_wdata,
    output logic [DATA_W/8-1:0]          data_wstrb,
    input  logic                         data_addr_ok,
    input  logic                         data_data_ok,
    input  logic                         ld_check_valid,
    input  logic [ADDR_W-1:0]            ld_check_addr,
    output logic                         ld_conflict,
    output logic                         sb_empty,
    output logic [$clog2(SB_DEPTH+1)-1:0] sb_count
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(SB_DEPTH + 1);
    localparam int SW = DATA_W / 8;
    localparam logic [CW-1:0] DEPTH_C = CW'(SB_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SW-1:0]     wstrb;
        logic [1:0]        size;
    } sb_entry_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    sb_entry_t             ent [SB_DEPTH];
    logic [SB_DEPTH-1:0]   ent_vld;
    logic [SB_DEPTH-1:0]   hit;
    logic [PW-1:0]         head_ptr, tail_ptr;
    logic [CW-1:0]         count, count_next;
    state_t                state, state_next;
    logic                  accept, pop;
    logic [1:0]            unused_ld_low;

    assign unused_ld_low  = ld_check_addr[1:0];
    assign cs_store_ready = (count < DEPTH_C);
    assign accept         = cs_store_valid && cs_store_ready;
    assign pop            = ((state == S_REQ) && data_addr_ok && data_data_ok) ||
                            ((state == S_WAIT) && data_data_ok);
    assign count_next     = count + CW'(accept) - CW'(pop);
    assign sb_count       = count;
    assign sb_empty       = (count == '0);

    // Payload needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (accept)
            ent[tail_ptr] <= '{addr: cs_store_addr, wdata: cs_store_wdata,
                               wstrb: cs_store_wstrb, size: cs_store_size};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            ent_vld  <= '0;
        end else begin
            count <= count_next;
            if (accept) begin
                tail_ptr          <= tail_ptr + PW'(1);
                ent_vld[tail_ptr] <= 1'b1;
            end
            if (pop) begin
                head_ptr          <= head_ptr + PW'(1);
                ent_vld[head_ptr] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (count != '0) state_next = S_REQ;
            S_REQ: begin
                if (data_addr_ok && !data_data_ok)     state_next = S_WAIT;
                else if (data_addr_ok && data_data_ok) state_next = (count_next != '0) ? S_REQ : S_IDLE;
            end
            S_WAIT: if (data_data_ok) state_next = (count_next != '0) ? S_REQ : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        data_req   = (state == S_REQ);
        data_wr    = data_req;
        data_addr  = ent[head_ptr].addr;
        data_wdata = ent[head_ptr].wdata;
        data_wstrb = ent[head_ptr].wstrb;
        data_size  = ent[head_ptr].size;
    end

    // The in-flight head stays valid until popped, so it is still probed.
    for (genvar g = 0; g < SB_DEPTH; g++) begin : g_match
        sb_entry_match #(.WORD_W(ADDR_W - 2)) u_match (
            .vld      (ent_vld[g]),
            .has_bytes(|ent[g].wstrb),
            .st_word  (ent[g].addr[ADDR_W-1:2]),
            .ld_word  (ld_check_addr[ADDR_W-1:2]),
            .hit      (hit[g])
        );
    end

    assign ld_conflict = ld_check_valid && (|hit);

    a_no_overflow:  assert property (@(posedge clk) disable iff (!resetn)
                                     !((count == DEPTH_C) && accept && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
                                     !((count == '0) && pop));
endmodule
